sequential_divider: RTL and testbench

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider.sv | 106 ++++++++++
 tb/tb_sequential_divider.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// Unsigned 2W-by-W restoring divider with divide-by-zero and quotient-overflow detection.
// Latency: WIDTH+1 cycles from accept to done; 1 cycle for divide-by-zero or overflow.
// Backpressure: none; start is sampled only in IDLE, and requests while busy are dropped.
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;       // latched divisor
  logic [WIDTH-1:0] rem;       // partial remainder, always < dvs between steps
  logic [WIDTH-1:0] acc;       // low dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH:0]   part_rem;  // shifted partial remainder; the extra bit keeps the carry
  logic             step_ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] acc_nxt;

  // One restoring shift-subtract step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    part_rem = {rem, acc[WIDTH-1]};
    step_ge  = (part_rem >= {1'b0, dvs});
    // When the subtraction happens the true difference is < dvs, so W-bit modular math is exact.
    rem_nxt  = step_ge ? (part_rem[WIDTH-1:0] - dvs) : part_rem[WIDTH-1:0];
    acc_nxt  = {acc[WIDTH-2:0], step_ge};
  end

  // Control FSM plus datapath registers; results only change on accept or at the end of RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvs         <= '0;
      rem         <= '0;
      acc         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvs         <= divisor;
            rem         <= dividend[2*WIDTH-1:WIDTH];
            acc         <= dividend[WIDTH-1:0];
            cnt         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
            end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              // High half already >= divisor means the quotient needs more than WIDTH bits.
              state     <= DONE;
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_nxt;
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            quotient  <= acc_nxt;
            remainder <= rem_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: accepts are observed and modelled with plain
// 64-bit arithmetic, and a monitor pops and compares on every done pulse, checking latency,
// result hold between operations, reset behaviour and back-to-back spacing.
module tb_sequential_divider;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [63:0]   dividend;
  logic [31:0]   divisor;
  logic [31:0]   quotient;
  logic [31:0]   remainder;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic          overflow;

  sequential_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;

  logic [31:0] last_q;
  logic [31:0] last_r;
  logic        last_dbz;
  logic        last_ovf;
  bit          hold_ok = 1'b0;

  // Reference: plain integer division on the full 64-bit dividend.
  function automatic exp_t model(logic [63:0] a, logic [31:0] b, int c);
    exp_t e;
    logic [63:0] q64;
    e.acc_cyc = c;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 32'd0) begin
      e.dbz = 1'b1;
      e.q   = 32'hFFFF_FFFF;
      e.r   = a[31:0];
      e.lat = 1;
    end else begin
      q64 = a / {32'd0, b};
      if (q64 > 64'h0000_0000_FFFF_FFFF) begin
        e.ovf = 1'b1;
        e.q   = 32'hFFFF_FFFF;
        e.r   = 32'd0;
        e.lat = 1;
      end else begin
        e.q   = q64[31:0];
        e.r   = 32'(a % {32'd0, b});
        e.lat = W + 1;
      end
    end
    return e;
  endfunction

  task automatic chk(string name, logic [79:0] act, logic [79:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
  endtask

  // Monitor: observe accepts, compare on done, and check that results hold while idle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_ok  = 1'b1;
      last_q   = '0;
      last_r   = '0;
      last_dbz = 1'b0;
      last_ovf = 1'b0;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 80'(done), 80'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("quotient",    80'(quotient),        80'(mon_e.q));
          chk("remainder",   80'(remainder),       80'(mon_e.r));
          chk("div_by_zero", 80'(div_by_zero),     80'(mon_e.dbz));
          chk("overflow",    80'(overflow),        80'(mon_e.ovf));
          chk("latency",     80'(cyc - mon_e.acc_cyc), 80'(mon_e.lat));
          last_q   = mon_e.q;
          last_r   = mon_e.r;
          last_dbz = mon_e.dbz;
          last_ovf = mon_e.ovf;
          hold_ok  = 1'b1;
        end
      end else if (!busy && hold_ok) begin
        chk("hold", {14'd0, quotient, remainder, div_by_zero, overflow},
                    {14'd0, last_q, last_r, last_dbz, last_ovf});
      end
      if (start && !busy) begin
        exp_q.push_back(model(dividend, divisor, cyc));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 200);
    if (busy) fail_now("idle_timeout");
  endtask

  // Issue one request; optionally spray ignored starts and input changes while busy.
  task automatic issue(logic [63:0] a, logic [31:0] b, bit junk);
    wait_idle();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
    if (junk) begin
      for (int k = 0; k < 40; k++) begin
        if (!busy) break;
        start    = 1'($urandom_range(0, 1));
        dividend = {$urandom, $urandom};
        divisor  = $urandom;
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int kind;
    int n;
    int ndone;
    int dcyc[3];
    logic [31:0] b;
    logic [31:0] hi;

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient",  80'(quotient),    80'd0);
    chk("rst_remainder", 80'(remainder),   80'd0);
    chk("rst_busy",      80'(busy),        80'd0);
    chk("rst_done",      80'(done),        80'd0);
    chk("rst_dbz",       80'(div_by_zero), 80'd0);
    chk("rst_ovf",       80'(overflow),    80'd0);
    rst = 1'b0;

    // Directed cases: normal, largest in-range quotient, overflow, divide by zero.
    issue(64'd100, 32'd7, 1'b0);
    issue(64'hFFFFFFFE_FFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue(64'h00000005_00000000, 32'd5, 1'b0);
    issue(64'h12345678_9ABCDEF0, 32'd0, 1'b0);

    // Ignored start mid-RUN, then reset mid-RUN: no done, all outputs cleared.
    wait_idle();
    start = 1'b1;
    dividend = 64'd100;
    divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    dividend = 64'd50;
    divisor = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrun_busy", 80'(busy), 80'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_quotient",  80'(quotient),    80'd0);
    chk("mrst_remainder", 80'(remainder),   80'd0);
    chk("mrst_busy",      80'(busy),        80'd0);
    chk("mrst_done",      80'(done),        80'd0);
    chk("mrst_dbz",       80'(div_by_zero), 80'd0);
    chk("mrst_ovf",       80'(overflow),    80'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(64'd50, 32'd3, 1'b0);

    // start held high: three back-to-back operations.
    wait_idle();
    start = 1'b1;
    dividend = 64'd1000;
    divisor = 32'd10;
    ndone = 0;
    n = 0;
    while (ndone < 3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        dcyc[ndone] = cyc;
        ndone++;
        if (ndone == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    if (ndone < 3) begin
      fail_now("b2b_done_count");
    end else begin
      chk("b2b_spacing1", 80'(dcyc[1] - dcyc[0]), 80'd34);
      chk("b2b_spacing2", 80'(dcyc[2] - dcyc[1]), 80'd34);
    end

    // Randomized operations with a mix of normal, overflow and divide-by-zero cases.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        issue({$urandom, $urandom}, 32'd0, 1'b1);
      end else if (kind == 1) begin
        b  = $urandom_range(1, 1000);
        hi = b + ((i % 3 == 0) ? 32'd0 : $urandom_range(0, 1000));
        issue({hi, $urandom}, b, 1'b1);
      end else begin
        b = (kind < 6) ? $urandom : $urandom_range(1, 1000);
        if (b == 32'd0) b = 32'd1;
        hi = $urandom % b;
        issue({hi, $urandom}, b, 1'b1);
      end
    end

    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 80'(exp_q.size()), 80'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
